chunk_row_start_gen: RTL
========================

// Module: chunk_row_start_gen
// PURPOSE
//  Multi-mode row-start generator for the ChunkAddrLooper. Accepts one chunk command (offsets, pads, bounds,
//  last counts, base address, per-dimension boundary mode), then walks the DIM-1 outer dimensions and emits one
//  registered row-start record per row: linear address, pad, valid, islast, row index. Feeds the column looper.
// PARAMETERS
//  GBW    32  global address width (TauCfg::GLOBAL_ADDR_BW)
//  DIM    4   dimensions; DIM-1 outer (row) dimensions are iterated, dim DIM-1 is the column dim
//  VSIZE  32  vector size; V_BW=$clog2(VSIZE) is the pad width
//  ROW_BW 16  row-index counter width
// PORTS
//  i_clk        in   1          clock
//  i_rst        in   1          reset, asynchronous, active-low
//  mofs_rdy     in   1          command valid
//  mofs_ack     out  1          command accepted
//  i_mofs       in   GBW x DIM  signed start offset per dim
//  i_mpad       in   V_BW x DIM pad per dim
//  i_mbound     in   GBW x DIM  bound per dim (address units); i_mbound[i+1] is the stride of dim i
//  i_mlast      in   GBW x DIM  last counter value per dim (inclusive)
//  i_maddr      in   GBW        base address
//  i_mode       in   2 x DIM    boundary mode per dim: 0 CLAMP, 1 WRAP, 2 SKIP, 3 = CLAMP
//  row_rdy      out  1          row record valid
//  row_ack      in   1          row record consumed
//  o_row_linear out  GBW        row-start linear address
//  o_row_pad    out  V_BW       row pad
//  o_row_valid  out  1          row fully in-bounds (or wrapped)
//  o_row_islast out  1          last row of the command
//  o_row_idx    out  ROW_BW     index of emitted-or-skipped row within command, from 0
// BEHAVIOUR
//  - Handshake: transfer when rdy&&ack in same cycle. row_rdy held and outputs stable until row_ack.
//  - Reset: state IDLE; mofs_ack, row_rdy, all o_row_* = 0; counters 0. Reset mid-command aborts it silently.
//  - States: IDLE -> (mofs_rdy) RUN -> (last row acked) IDLE. mofs_ack = mofs_rdy && IDLE (one bubble per cmd).
//  - On accept all i_* are latched; later input changes have no effect on the running command.
//  - Counters c[i], i=0..DIM-2, start 0, step i_mbound[i+1]; dim DIM-2 innermost. c[i]==mlast[i] => at-end;
//    at-end dim resets to 0 and carries outward. Last row: all dims at-end.
//  - Per dim: u=c[i]+mofs[i] (GBW, modular). Neg = u[GBW-1]; Over = $signed(u)>=$signed(bound[i]).
//    CLAMP: Neg->0, Over->bound[i]-bound[i+1], flag invalid. WRAP: Neg->u+bound[i], Over->u-bound[i],
//    always valid (single correction; |mofs[i]|<bound[i] required). SKIP: as CLAMP, but row is suppressed.
//  - o_row_linear = maddr + sum of corrected u[i] (GBW, truncating). o_row_valid = AND of per-dim valid.
//  - o_row_pad = OR of mpad[i] over at-end dims i<DIM-1, OR mpad[DIM-1] when row is last.
//  - Latency: first row_rdy the cycle after mofs handshake. Throughput 1 row/cycle with row_ack held high;
//    output register loads when !row_rdy || row_ack (next row computed combinationally from counters).
//  - SKIP: a non-last row invalid in any SKIP dim is not emitted; counters advance 1 row/cycle, row_rdy low.
//    The last row is always emitted (o_row_valid=0 if invalid) so islast always arrives.
//  - o_row_idx increments on every row step (emitted or skipped); wraps modulo 2^ROW_BW.
//  - o_row_islast=1 only on the last record; on its ack row_rdy drops and state returns IDLE same edge.
//  - DIM-1 dims with mlast=0 give exactly one row (islast=1 immediately).
// TESTING
//  - DIM=3, bound={64,8,1}, last={16,4}(2x... rows 3x5 via stride), mofs=0, CLAMP, ack=1 -> 15 rows, addresses
//    maddr+8*r+c pattern, valid=1, islast only on 15th, idx 0..14, back-to-back 1/cycle.
//  - Same, mofs[0]=-8 CLAMP -> first row group clamped to 0, valid=0; WRAP -> address 56, valid=1.
//  - mofs[1]=+6 past bound, SKIP on dim1 -> out-of-range rows absent, idx shows gaps, last row still
//    emitted with valid=0, islast=1.
//  - Random row_ack backpressure (30% low) -> outputs never change while row_rdy&&!row_ack; no row lost/duplicated.
//  - Change i_* after mofs_ack, and assert i_rst low mid-RUN -> stream unaffected by inputs; on reset row_rdy=0
//    immediately, next command starts with idx 0.
//  - mlast all 0, mpad={1,2,3} -> single record, pad=3'b011|... = OR(1,2,3)=3, islast=1, mofs_ack next after ack.

Source files
------------

// File: rtl/chunk_row_start_gen_if.sv
// Command and row-record bundle for chunk_row_start_gen.
//   master : command producer / row consumer (drives mofs_rdy, i_*, row_ack)
//   slave  : the row-start generator (drives mofs_ack, row_rdy, o_row_*)
// Command side : mofs_rdy/mofs_ack handshake with offsets, pads, bounds,
//                last counts, base address and per-dim boundary mode.
// Row side     : row_rdy/row_ack handshake with linear address, pad, valid,
//                islast and row index.
interface chunk_row_start_gen_if #(
    parameter int GBW    = 32,
    parameter int DIM    = 4,
    parameter int VSIZE  = 32,
    parameter int ROW_BW = 16
);
    localparam int V_BW = (VSIZE > 1) ? $clog2(VSIZE) : 1;

    logic                      mofs_rdy;
    logic                      mofs_ack;
    logic [DIM-1:0][GBW-1:0]   i_mofs;
    logic [DIM-1:0][V_BW-1:0]  i_mpad;
    logic [DIM-1:0][GBW-1:0]   i_mbound;
    logic [DIM-1:0][GBW-1:0]   i_mlast;
    logic [GBW-1:0]            i_maddr;
    logic [DIM-1:0][1:0]       i_mode;

    logic                      row_rdy;
    logic                      row_ack;
    logic [GBW-1:0]            o_row_linear;
    logic [V_BW-1:0]           o_row_pad;
    logic                      o_row_valid;
    logic                      o_row_islast;
    logic [ROW_BW-1:0]         o_row_idx;

    modport master (
        output mofs_rdy, i_mofs, i_mpad, i_mbound, i_mlast, i_maddr, i_mode, row_ack,
        input  mofs_ack, row_rdy, o_row_linear, o_row_pad, o_row_valid, o_row_islast, o_row_idx
    );

    modport slave (
        input  mofs_rdy, i_mofs, i_mpad, i_mbound, i_mlast, i_maddr, i_mode, row_ack,
        output mofs_ack, row_rdy, o_row_linear, o_row_pad, o_row_valid, o_row_islast, o_row_idx
    );
endinterface

// File: rtl/chunk_row_start_gen.sv
// Row-start generator for the chunk address looper.
// Accepts one chunk command, walks the DIM-1 outer dimensions (dim DIM-2
// innermost) and emits one registered row-start record per row.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-low reset
//   bus    : chunk_row_start_gen_if.slave (command in, row records out)
module chunk_row_start_gen #(
    parameter int GBW    = 32,
    parameter int DIM    = 4,
    parameter int VSIZE  = 32,
    parameter int ROW_BW = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    chunk_row_start_gen_if.slave   bus
);
    localparam int V_BW = (VSIZE > 1) ? $clog2(VSIZE) : 1;
    localparam int RD   = DIM - 1;   // number of row dimensions

    localparam logic [1:0] MODE_WRAP = 2'd1;
    localparam logic [1:0] MODE_SKIP = 2'd2;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                    state_q;
    logic [RD-1:0][GBW-1:0]    mofs_q;
    logic [RD-1:0][GBW-1:0]    mlast_q;
    logic [RD-1:0][1:0]        mode_q;
    logic [DIM-1:0][GBW-1:0]   mbound_q;
    logic [DIM-1:0][V_BW-1:0]  mpad_q;
    logic [GBW-1:0]            maddr_q;
    logic [RD-1:0][GBW-1:0]    cnt_q;
    logic [RD-1:0][GBW-1:0]    cnt_d;
    logic [ROW_BW-1:0]         idx_q;
    logic                      gen_done_q;   // last row has been generated

    logic                      row_rdy_q;
    logic [GBW-1:0]            row_linear_q;
    logic [V_BW-1:0]           row_pad_q;
    logic                      row_valid_q;
    logic                      row_islast_q;
    logic [ROW_BW-1:0]         row_idx_q;

    logic idle;
    logic step_en;
    logic finish;

    // While idle the first row is computed straight from the command inputs,
    // so it can be registered on the accepting edge itself.
    logic [RD-1:0][GBW-1:0]    src_mofs;
    logic [RD-1:0][GBW-1:0]    src_last;
    logic [RD-1:0][1:0]        src_mode;
    logic [DIM-1:0][GBW-1:0]   src_bound;
    logic [DIM-1:0][V_BW-1:0]  src_pad;
    logic [GBW-1:0]            src_maddr;

    assign idle      = (state_q == ST_IDLE);
    assign src_mofs  = idle ? bus.i_mofs[RD-1:0]  : mofs_q;
    assign src_last  = idle ? bus.i_mlast[RD-1:0] : mlast_q;
    assign src_mode  = idle ? bus.i_mode[RD-1:0]  : mode_q;
    assign src_bound = idle ? bus.i_mbound        : mbound_q;
    assign src_pad   = idle ? bus.i_mpad          : mpad_q;
    assign src_maddr = idle ? bus.i_maddr         : maddr_q;

    // Per-dimension boundary correction.
    logic [GBW-1:0] corr_w   [RD];
    logic           ok_w     [RD];
    logic           skip_w   [RD];
    logic           at_end_w [RD];

    for (genvar gi = 0; gi < RD; gi++) begin : g_dim
        logic [GBW-1:0] u;
        logic           neg;
        logic           over;
        logic [GBW-1:0] corr;
        logic           ok;

        assign u    = cnt_q[gi] + src_mofs[gi];
        assign neg  = u[GBW-1];
        assign over = !neg && ($signed(u) >= $signed(src_bound[gi]));

        always_comb begin
            corr = u;
            ok   = 1'b1;
            if (src_mode[gi] == MODE_WRAP) begin
                if (neg)       corr = u + src_bound[gi];
                else if (over) corr = u - src_bound[gi];
            end else if (neg) begin
                corr = '0;
                ok   = 1'b0;
            end else if (over) begin
                // Clamp to the start of the last in-bounds step of this dim.
                corr = src_bound[gi] - src_bound[gi+1];
                ok   = 1'b0;
            end
        end

        assign corr_w[gi]   = corr;
        assign ok_w[gi]     = ok;
        assign skip_w[gi]   = (src_mode[gi] == MODE_SKIP) && !ok;
        assign at_end_w[gi] = (cnt_q[gi] == src_last[gi]);
    end

    // Row record and counter advance for the row the counters point at.
    logic [GBW-1:0]  sum_lin;
    logic [V_BW-1:0] pad_c;
    logic            row_ok;
    logic            skip_hit;
    logic            is_last;
    logic            skip_row;

    always_comb begin
        logic carry;
        sum_lin  = src_maddr;
        pad_c    = '0;
        row_ok   = 1'b1;
        skip_hit = 1'b0;
        is_last  = 1'b1;
        for (int i = 0; i < RD; i++) begin
            sum_lin  = sum_lin + corr_w[i];
            row_ok   = row_ok & ok_w[i];
            skip_hit = skip_hit | skip_w[i];
            is_last  = is_last & at_end_w[i];
            if (at_end_w[i]) pad_c = pad_c | src_pad[i];
        end
        if (is_last) pad_c = pad_c | src_pad[DIM-1];

        // Innermost dim steps; an at-end dim wraps to 0 and carries outward.
        carry = 1'b1;
        for (int i = RD - 1; i >= 0; i--) begin
            cnt_d[i] = cnt_q[i];
            if (carry) begin
                if (at_end_w[i]) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + src_bound[i+1];
                    carry    = 1'b0;
                end
            end
        end
    end

    // The last row is always emitted so the consumer sees islast.
    assign skip_row = skip_hit && !is_last;
    assign step_en  = idle ? bus.mofs_rdy : ((!row_rdy_q || bus.row_ack) && !gen_done_q);
    assign finish   = !idle && row_rdy_q && bus.row_ack && row_islast_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            mofs_q       <= '0;
            mlast_q      <= '0;
            mode_q       <= '0;
            mbound_q     <= '0;
            mpad_q       <= '0;
            maddr_q      <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            gen_done_q   <= 1'b0;
            row_rdy_q    <= 1'b0;
            row_linear_q <= '0;
            row_pad_q    <= '0;
            row_valid_q  <= 1'b0;
            row_islast_q <= 1'b0;
            row_idx_q    <= '0;
        end else begin
            if (idle && bus.mofs_rdy) begin
                state_q  <= ST_RUN;
                mofs_q   <= bus.i_mofs[RD-1:0];
                mlast_q  <= bus.i_mlast[RD-1:0];
                mode_q   <= bus.i_mode[RD-1:0];
                mbound_q <= bus.i_mbound;
                mpad_q   <= bus.i_mpad;
                maddr_q  <= bus.i_maddr;
            end
            if (finish) begin
                state_q    <= ST_IDLE;
                row_rdy_q  <= 1'b0;
                cnt_q      <= '0;
                idx_q      <= '0;
                gen_done_q <= 1'b0;
            end
            if (step_en) begin
                cnt_q      <= cnt_d;
                idx_q      <= idx_q + 1'b1;
                gen_done_q <= is_last;
                if (skip_row) begin
                    row_rdy_q <= 1'b0;
                end else begin
                    row_rdy_q    <= 1'b1;
                    row_linear_q <= sum_lin;
                    row_pad_q    <= pad_c;
                    row_valid_q  <= row_ok;
                    row_islast_q <= is_last;
                    row_idx_q    <= idx_q;
                end
            end
        end
    end

    assign bus.mofs_ack     = bus.mofs_rdy && idle;
    assign bus.row_rdy      = row_rdy_q;
    assign bus.o_row_linear = row_linear_q;
    assign bus.o_row_pad    = row_pad_q;
    assign bus.o_row_valid  = row_valid_q;
    assign bus.o_row_islast = row_islast_q;
    assign bus.o_row_idx    = row_idx_q;
endmodule
